// File: rtl/acc_queue.sv
`default_nettype none
// ============================================================================
// Module   : acc_queue
// Purpose  : In-order issue queue for the accumulator unit with CDB operand
//            wakeup and branch-speculative flush on misprediction.
// Revision : 1.0  initial release
// ============================================================================
module acc_queue #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_WIDTH = 6,
    parameter int N_B_ENTRY = 4,
    parameter int TAG_W     = ROB_WIDTH,
    parameter int BC_W      = $clog2(N_B_ENTRY) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic                    issue_opd_valid,
    input  logic [TAG_W-1:0]        issue_opd_tag,
    input  logic [DATA_W-1:0]       issue_opd_data,
    input  logic [BC_W-1:0]         issue_b_count,
    input  logic                    cdb_valid,
    input  logic [TAG_W-1:0]        cdb_tag,
    input  logic [DATA_W-1:0]       cdb_data,
    input  logic                    b_commit,
    input  logic                    failure,
    output logic                    acc_valid,
    input  logic                    acc_ready,
    output logic [DATA_W-1:0]       acc_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [DATA_W-1:0]  data_q      [DEPTH];
    logic [DATA_W-1:0]  data_d      [DEPTH];
    logic [TAG_W-1:0]   tag_q       [DEPTH];
    logic [TAG_W-1:0]   tag_d       [DEPTH];
    logic [BC_W-1:0]    bc_q        [DEPTH];
    logic [BC_W-1:0]    bc_d        [DEPTH];
    logic [DEPTH-1:0]   opd_valid_q;
    logic [DEPTH-1:0]   opd_valid_d;
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [C_PTR_W-1:0] head_q;
    logic [C_PTR_W-1:0] head_d;
    logic [C_PTR_W-1:0] tail_q;
    logic [C_PTR_W-1:0] tail_d;
    logic [C_CNT_W-1:0] count_q;
    logic [C_CNT_W-1:0] count_d;

    logic               pop;
    logic               push;
    logic               found;
    logic [C_CNT_W-1:0] keep;
    logic [C_PTR_W-1:0] idx;

    assign acc_valid   = (count_q != '0) && valid_q[head_q] &&
                         (bc_q[head_q] == '0) && opd_valid_q[head_q];
    assign acc_data    = data_q[head_q];
    assign pop         = acc_valid && acc_ready;
    assign issue_ready = !failure && ((count_q < C_CNT_W'(DEPTH)) || pop);
    assign push        = issue_valid && issue_ready;
    assign count       = count_q;

    always_comb begin
        data_d      = data_q;
        tag_d       = tag_q;
        bc_d        = bc_q;
        opd_valid_d = opd_valid_q;
        valid_d     = valid_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        found       = 1'b0;
        keep        = '0;
        idx         = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (!opd_valid_q[i] && cdb_valid && (cdb_tag == tag_q[i])) begin
                opd_valid_d[i] = 1'b1;
                data_d[i]      = cdb_data;
            end
            if (b_commit && (bc_q[i] != '0)) begin
                bc_d[i] = bc_q[i] - BC_W'(1);
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + C_PTR_W'(1);
        end

        // The new entry's branch count is already the next-cycle value.
        if (push) begin
            valid_d[tail_q]     = 1'b1;
            tag_d[tail_q]       = issue_opd_tag;
            bc_d[tail_q]        = issue_b_count;
            opd_valid_d[tail_q] = issue_opd_valid;
            data_d[tail_q]      = issue_opd_data;
            if (!issue_opd_valid && cdb_valid && (cdb_tag == issue_opd_tag)) begin
                opd_valid_d[tail_q] = 1'b1;
                data_d[tail_q]      = cdb_data;
            end
            tail_d = tail_q + C_PTR_W'(1);
        end

        // Speculative entries form a suffix; keep only the confirmed prefix.
        if (failure) begin
            for (int j = 0; j < DEPTH; j++) begin
                idx = head_q + C_PTR_W'(j);
                if (C_CNT_W'(j) < count_q) begin
                    if (bc_q[idx] != '0) begin
                        found = 1'b1;
                    end
                    if (found) begin
                        valid_d[idx] = 1'b0;
                    end else begin
                        keep = C_CNT_W'(j + 1);
                    end
                end
            end
            tail_d  = head_q + keep[C_PTR_W-1:0];
            count_d = keep - C_CNT_W'(pop);
        end else begin
            count_d = count_q + C_CNT_W'(push) - C_CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        data_q      <= data_d;
        tag_q       <= tag_d;
        bc_q        <= bc_d;
        opd_valid_q <= opd_valid_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_queue
// Purpose  : Directed table-driven bench for acc_queue (DEPTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_acc_queue;
    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_opd_valid;
    logic [5:0]  issue_opd_tag;
    logic [31:0] issue_opd_data;
    logic [2:0]  issue_b_count;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        b_commit;
    logic        failure;
    logic        acc_valid;
    logic        acc_ready;
    logic [31:0] acc_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    acc_queue #(
        .DEPTH     (4),
        .DATA_W    (32),
        .ROB_WIDTH (6),
        .N_B_ENTRY (4)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_opd_valid (issue_opd_valid),
        .issue_opd_tag   (issue_opd_tag),
        .issue_opd_data  (issue_opd_data),
        .issue_b_count   (issue_b_count),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .b_commit        (b_commit),
        .failure         (failure),
        .acc_valid       (acc_valid),
        .acc_ready       (acc_ready),
        .acc_data        (acc_data),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ov;
        logic [5:0]  tag;
        logic [31:0] data;
        logic [2:0]  bc;
        logic        cv;
        logic [5:0]  ctag;
        logic [31:0] cdata;
        logic        bcm;
        logic        fail;
        logic        ar;
        logic        e_av;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_ir;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic iv, input logic ov, input logic [5:0] tag,
                       input logic [31:0] data, input logic [2:0] bc,
                       input logic cv, input logic [5:0] ctag, input logic [31:0] cdata,
                       input logic bcm, input logic fail, input logic ar,
                       input logic e_av, input logic [31:0] e_data,
                       input logic [2:0] e_cnt, input logic e_ir);
        vec_t v;
        v = '{iv, ov, tag, data, bc, cv, ctag, cdata, bcm, fail, ar,
              e_av, e_data, e_cnt, e_ir};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ov, input logic [5:0] tag,
                         input logic [31:0] data, input logic [2:0] bc,
                         input logic cv, input logic [5:0] ctag, input logic [31:0] cdata,
                         input logic bcm, input logic fail, input logic ar);
        issue_valid     = iv;
        issue_opd_valid = ov;
        issue_opd_tag   = tag;
        issue_opd_data  = data;
        issue_b_count   = bc;
        cdb_valid       = cv;
        cdb_tag         = ctag;
        cdb_data        = cdata;
        b_commit        = bcm;
        failure         = fail;
        acc_ready       = ar;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // iv ov tag data bc | cv ctag cdata | bcm fail ar || av data cnt ir
        // single ready entry dispatches next cycle
        row(1, 1, 0, 32'h3F800000, 0, 0, 0, 0,            0, 0, 1, 0, 0,            0, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'h3F800000, 1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0, 0,            0, 1);
        // CDB wakeup; a non-matching tag leaves the entry asleep
        row(1, 0, 5, 0,            0, 0, 0, 0,            0, 0, 1, 0, 0,            0, 1);
        row(0, 0, 0, 0,            0, 1, 6, 32'hDEADBEEF, 0, 0, 1, 0, 0,            1, 1);
        row(0, 0, 0, 0,            0, 1, 5, 32'h40000000, 0, 0, 1, 0, 0,            1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'h40000000, 1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0, 0,            0, 1);
        // same-cycle bypass at enqueue
        row(1, 0, 3, 0,            0, 1, 3, 32'h12345678, 0, 0, 1, 0, 0,            0, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'h12345678, 1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0, 0,            0, 1);
        // fill, full back-pressure, push+pop when full, pointer wrap
        row(1, 1, 0, 32'h11,       0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 1);
        row(1, 1, 0, 32'h22,       0, 0, 0, 0,            0, 0, 0, 1, 32'h11,       1, 1);
        row(1, 1, 0, 32'h33,       0, 0, 0, 0,            0, 0, 0, 1, 32'h11,       2, 1);
        row(1, 1, 0, 32'h44,       0, 0, 0, 0,            0, 0, 0, 1, 32'h11,       3, 1);
        row(1, 1, 0, 32'h55,       0, 0, 0, 0,            0, 0, 0, 1, 32'h11,       4, 0);
        row(1, 1, 0, 32'h55,       0, 0, 0, 0,            0, 0, 1, 1, 32'h11,       4, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'h22,       4, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'h33,       3, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'h44,       2, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'h55,       1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 1);
        // branch counts {0,1,2} then failure keeps only the first
        row(1, 1, 0, 32'hA1,       0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 1);
        row(1, 1, 0, 32'hA2,       1, 0, 0, 0,            0, 0, 0, 1, 32'hA1,       1, 1);
        row(1, 1, 0, 32'hA3,       2, 0, 0, 0,            0, 0, 0, 1, 32'hA1,       2, 1);
        row(1, 1, 0, 32'h99,       0, 0, 0, 0,            0, 1, 0, 1, 32'hA1,       3, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'hA1,       1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 1);
        // branch counts {0,1,2} then one b_commit
        row(1, 1, 0, 32'hB1,       0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 1);
        row(1, 1, 0, 32'hB2,       1, 0, 0, 0,            0, 0, 0, 1, 32'hB1,       1, 1);
        row(1, 1, 0, 32'hB3,       2, 0, 0, 0,            0, 0, 0, 1, 32'hB1,       2, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            1, 0, 0, 1, 32'hB1,       3, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'hB1,       3, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'hB2,       2, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0, 0,            1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            1, 0, 0, 0, 0,            1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'hB3,       1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 1);
        // failure with head pop and CDB match on the flushed entry
        row(1, 1, 0, 32'hC1,       0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 1);
        row(1, 0, 9, 0,            1, 0, 0, 0,            0, 0, 0, 1, 32'hC1,       1, 1);
        row(0, 0, 0, 0,            0, 1, 9, 32'h77,       0, 1, 1, 1, 32'hC1,       2, 0);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0, 0,            0, 1);
        // enqueued branch count is not decremented by a same-cycle b_commit
        row(1, 1, 0, 32'hD1,       1, 0, 0, 0,            1, 0, 0, 0, 0,            0, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0, 0,            1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            1, 0, 1, 0, 0,            1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 32'hD1,       1, 1);
        row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 1);

        #12;
        chk("reset count", 32'(count), 32'd0);
        chk("reset acc_valid", 32'(acc_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].iv, tbl[i].ov, tbl[i].tag, tbl[i].data, tbl[i].bc,
                  tbl[i].cv, tbl[i].ctag, tbl[i].cdata,
                  tbl[i].bcm, tbl[i].fail, tbl[i].ar);
            #3;
            chk($sformatf("row%0d acc_valid", i), 32'(acc_valid), 32'(tbl[i].e_av));
            chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("row%0d issue_ready", i), 32'(issue_ready), 32'(tbl[i].e_ir));
            if (tbl[i].e_av) begin
                chk($sformatf("row%0d acc_data", i), acc_data, tbl[i].e_data);
            end
        end

        // asynchronous reset with three entries held
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 drive(1, 1, 0, 32'(k + 1), 0, 0, 0, 0, 0, 0, 0);
        end
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("pre-reset count", 32'(count), 32'd3);
        chk("pre-reset acc_valid", 32'(acc_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async reset count", 32'(count), 32'd0);
        chk("async reset acc_valid", 32'(acc_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post-reset issue_ready", 32'(issue_ready), 32'd1);
        chk("post-reset count", 32'(count), 32'd0);
        chk("post-reset acc_valid", 32'(acc_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/acc_queue.md
ACC_QUEUE -- requirements
Module: acc_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_W, default 32, operand width.
REQ-003 SHALL have parameter TAG_W, default ROB_WIDTH, CDB tag width.
REQ-004 SHALL have parameter BC_W, default $clog2(N_B_ENTRY)+1, branch-count width.
REQ-005 SHALL have port clk  input  1  clock; one clock domain, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports issue_valid input 1 / issue_ready output 1: enqueue handshake.
REQ-008 SHALL have ports issue_opd_valid input 1, issue_opd_tag input TAG_W, issue_opd_data input DATA_W: operand from FPR read.
REQ-009 SHALL have port issue_b_count  input  BC_W  unresolved-branch count for the new entry (already next-cycle value).
REQ-010 SHALL have ports cdb_valid input 1, cdb_tag input TAG_W, cdb_data input DATA_W: FPR result broadcast.
REQ-011 SHALL have port b_commit  input  1  one older branch resolved correctly this cycle.
REQ-012 SHALL have port failure  input  1  misprediction flush.
REQ-013 SHALL have ports acc_valid output 1, acc_ready input 1, acc_data output DATA_W: dispatch to accumulator unit.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 SHALL hold entries in a circular buffer with head/tail pointers wrapping modulo DEPTH, program order head to tail.
REQ-016 SHALL set acc_valid = count!=0 && head.b_count==0 && head.opd_valid; acc_data = head.data, combinational.
REQ-017 SHALL pop head (head+1, count-1) when acc_valid && acc_ready.
REQ-018 SHALL set issue_ready = !failure && (count<DEPTH || pop).
REQ-019 SHALL write tail entry (tail+1, count+1) when issue_valid && issue_ready; simultaneous push and pop leaves count unchanged.
REQ-020 SHALL capture cdb_data with opd_valid=1 at enqueue when !issue_opd_valid && cdb_valid && cdb_tag==issue_opd_tag (same-cycle bypass).
REQ-021 SHALL, each cycle, for every stored entry with !opd_valid and cdb_valid && cdb_tag==opd_tag, set opd_valid=1 and data=cdb_data; entries with opd_valid=1 never change data.
REQ-022 SHALL decrement every stored entry's b_count by b_commit, saturating at 0; the enqueued entry takes issue_b_count undecremented.
REQ-023 SHALL, on failure, invalidate all entries with b_count!=0 (a contiguous suffix) by moving tail back to the first such entry and reducing count accordingly; confirmed entries survive.
REQ-024 SHALL allow pop of a confirmed head in a failure cycle; no enqueue occurs in a failure cycle.
REQ-025 SHALL drop a failure-flushed entry even if a CDB match occurs the same cycle.
REQ-026 SHALL present acc_valid=0 when count==0 regardless of stale storage.

Reset
REQ-027 SHALL, while rst=1, asynchronously force head=0, tail=0, count=0, all entry valid bits 0, acc_valid=0.
REQ-028 SHALL present issue_ready=1 in the first cycle after rst deasserts (with failure=0); reset mid-operation discards all entries.

Verification
REQ-029 SHALL verify: enqueue opd_valid=1 data=0x3F800000 b_count=0, acc_ready=1 -> acc_valid=1 next cycle with acc_data=0x3F800000, count 1->0.
REQ-030 SHALL verify: enqueue opd_valid=0 tag=5; two cycles later cdb_valid tag=5 data=0x40000000 -> acc_valid=1 the following cycle, acc_data=0x40000000; tag=6 broadcast does not wake it.
REQ-031 SHALL verify: DEPTH=4 filled, acc_ready=0 -> issue_ready=0, count=4; then acc_ready=1 with issue_valid=1 -> push+pop same cycle, count stays 4, tail wraps to 0.
REQ-032 SHALL verify: entries b_count {0,1,2}, failure=1 -> count=1, only first entry remains and dispatches; one b_commit instead -> counts {0,0,1}, two entries dispatchable in order.
REQ-033 SHALL verify: enqueue with tag=3 while cdb_valid tag=3 data=0x12345678 -> entry stored ready, acc_data=0x12345678 next cycle.
REQ-034 SHALL verify: rst asserted with 3 entries held -> count=0, acc_valid=0 immediately; issue_ready=1 after release.
